// File: rtl/t5_norm_stage_if.sv
// t5_norm_stage_if: valid/ready input beat and normalised output beat of the T5 normalisation stage
interface t5_norm_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  cont;
    logic [74:0] p_reg;
    logic [9:0]  sh_num;
    logic [1:0]  esh;
    logic [11:0] E;
    logic [11:0] E_H;
    logic [1:0]  sgn;
    logic [7:0]  trap;
    logic        out_valid;
    logic        out_ready;
    logic [55:0] norm;
    logic [11:0] E_out;
    logic [11:0] E_H_out;
    logic [5:0]  flags;
    logic [2:0]  cont_o;
    logic [1:0]  sgn_o;
    logic [7:0]  trap_o;
    modport master (
        output in_valid, cont, p_reg, sh_num, esh, E, E_H, sgn, trap, out_ready,
        input  in_ready, out_valid, norm, E_out, E_H_out, flags, cont_o, sgn_o, trap_o
    );
    modport slave (
        input  in_valid, cont, p_reg, sh_num, esh, E, E_H, sgn, trap, out_ready,
        output in_ready, out_valid, norm, E_out, E_H_out, flags, cont_o, sgn_o, trap_o
    );
endinterface

// File: rtl/t5_norm_stage.sv
// t5_norm_stage: two-stage normaliser (coarse shift + sticky, then fine shift, LZA correction, G/R/S, exponent flags).
// T5_LZA_CORR_EN: derive the 1-bit LZA correction from the post-shift lane MSB instead of esh.
module t5_norm_stage #(
    parameter int DP_EMAX = 2047,
    parameter int SP_EMAX = 255
) (
    input logic            clk,
    input logic            rst,
    t5_norm_stage_if.slave bus
);
    localparam logic signed [11:0] DP_MAX = 12'(DP_EMAX);
    localparam logic signed [11:0] SP_MAX = 12'(SP_EMAX);

    function automatic logic [2:0] lane_flags(input logic z, input logic [11:0] e, input logic signed [11:0] emax);
        lane_flags = {!z && $signed(e) >= emax, !z && $signed(e) <= 12'sd0, z};
    endfunction

    logic        en;
    logic        dbl, sgl;
    logic [6:0]  sh_d;
    logic [74:0] cd, mag_d;
    logic [36:0] cl, ch;
    logic [1:0]  stk_d;
    logic [2:0]  z_d;

    logic        a_valid;
    logic [74:0] a_mag;
    logic [1:0]  a_stk;
    logic [2:0]  a_z;
    logic [6:0]  a_sh_d;
    logic [4:0]  a_sh_l, a_sh_h;
    logic [11:0] a_e, a_eh;
    logic [2:0]  a_cont;
    logic [1:0]  a_sgn;
    logic [7:0]  a_trap;

    assign en = !bus.out_valid | bus.out_ready;
    assign bus.in_ready = en;

    assign dbl   = bus.cont == 3'b000 || bus.cont == 3'b010;
    assign sgl   = bus.cont == 3'b001;
    assign sh_d  = bus.sh_num[6:0] > 7'd74 ? 7'd74 : bus.sh_num[6:0];
    assign cd    = bus.p_reg << {sh_d[6:3], 3'b000};
    // a 5-bit single count never exceeds the 36 clamp, so no clamp logic is needed per lane
    assign cl    = bus.p_reg[36:0] << {bus.sh_num[4:3], 3'b000};
    assign ch    = bus.p_reg[74:38] << {bus.sh_num[9:8], 3'b000};
    // low bits land below R even after the largest fine+corr shift, so fold them into sticky now
    assign mag_d = dbl ? {cd[74:12], 12'b0} : sgl ? {ch[36:3], 3'b000, 1'b0, cl[36:3], 3'b000} : '0;
    assign stk_d = dbl ? {1'b0, |cd[11:0]} : sgl ? {|ch[2:0], |cl[2:0]} : 2'b00;
    assign z_d   = {bus.p_reg[74:38] == '0, bus.p_reg[36:0] == '0, bus.p_reg == '0};

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid <= 1'b0;
            a_mag   <= '0;
            a_stk   <= '0;
            a_z     <= '0;
            a_sh_d  <= '0;
            a_sh_l  <= '0;
            a_sh_h  <= '0;
            a_e     <= '0;
            a_eh    <= '0;
            a_cont  <= '0;
            a_sgn   <= '0;
            a_trap  <= '0;
        end else if (en) begin
            a_valid <= bus.in_valid;
            a_mag   <= mag_d;
            a_stk   <= stk_d;
            a_z     <= z_d;
            a_sh_d  <= sh_d;
            a_sh_l  <= bus.sh_num[4:0];
            a_sh_h  <= bus.sh_num[9:5];
            a_e     <= bus.E;
            a_eh    <= bus.E_H;
            a_cont  <= bus.cont;
            a_sgn   <= bus.sgn;
            a_trap  <= bus.trap;
        end
    end

    logic        k_d, k_l, k_h;
    logic        b_dbl, b_sgl;
    logic [74:0] fd, nd;
    logic [36:0] fl, fh, nl, nh;
    logic [27:0] wl, wh;
    logic        s_d;
    logic [11:0] ed, el, eh;
    logic [55:0] b_norm;
    logic [11:0] b_e, b_eh;
    logic [5:0]  b_flags;

    assign fd = a_mag << a_sh_d[2:0];
    assign fl = a_mag[36:0] << a_sh_l[2:0];
    assign fh = a_mag[74:38] << a_sh_h[2:0];
`ifdef T5_LZA_CORR_EN
    assign k_d = !fd[74];
    assign k_l = !fl[36];
    assign k_h = !fh[36];
`else
    logic [1:0] a_esh;
    always_ff @(posedge clk) begin
        if (rst) a_esh <= '0;
        else if (en) a_esh <= bus.esh;
    end
    assign k_d = a_esh[0];
    assign k_l = a_esh[0];
    assign k_h = a_esh[1];
`endif
    assign nd  = fd << k_d;
    assign nl  = fl << k_l;
    assign nh  = fh << k_h;
    assign s_d = |nd[19:0] | a_stk[0];
    assign wl  = {nl[36:11], |nl[10:0] | a_stk[0], 1'b0};
    assign wh  = {nh[36:11], |nh[10:0] | a_stk[1], 1'b0};
    assign ed  = a_e - {5'b0, a_sh_d} - {11'b0, k_d};
    assign el  = a_e - {7'b0, a_sh_l} - {11'b0, k_l};
    assign eh  = a_eh - {7'b0, a_sh_h} - {11'b0, k_h};
    assign b_dbl = a_cont == 3'b000 || a_cont == 3'b010;
    assign b_sgl = a_cont == 3'b001;

    always_comb begin
        b_norm  = '0;
        b_e     = '0;
        b_eh    = '0;
        b_flags = '0;
        if (b_dbl) begin
            b_norm       = a_z[0] ? '0 : {nd[74:20], s_d};
            b_e          = a_z[0] ? '0 : ed;
            b_flags[2:0] = lane_flags(a_z[0], ed, DP_MAX);
        end else if (b_sgl) begin
            b_norm  = {a_z[2] ? 28'b0 : wh, a_z[1] ? 28'b0 : wl};
            b_e     = a_z[1] ? '0 : el;
            b_eh    = a_z[2] ? '0 : eh;
            b_flags = {lane_flags(a_z[2], eh, SP_MAX), lane_flags(a_z[1], el, SP_MAX)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.norm      <= '0;
            bus.E_out     <= '0;
            bus.E_H_out   <= '0;
            bus.flags     <= '0;
            bus.cont_o    <= '0;
            bus.sgn_o     <= '0;
            bus.trap_o    <= '0;
        end else if (en) begin
            bus.out_valid <= a_valid;
            bus.norm      <= b_norm;
            bus.E_out     <= b_e;
            bus.E_H_out   <= b_eh;
            bus.flags     <= b_flags;
            bus.cont_o    <= a_cont;
            bus.sgn_o     <= a_sgn;
            bus.trap_o    <= a_trap;
        end
    end
endmodule

// File: tb/tb_t5_norm_stage.sv
// tb_t5_norm_stage: directed vectors with hand-computed results for the T5 normalisation stage
module tb_t5_norm_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    t5_norm_stage_if bus();
    t5_norm_stage dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

`ifdef T5_LZA_CORR_EN
    localparam logic CORR = 1'b1;
`else
    localparam logic CORR = 1'b0;
`endif
    localparam logic [55:0] TOP = 56'h80_0000_0000_0000;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] c, input logic [74:0] p, input logic [9:0] sh,
                         input logic [1:0] es, input logic [11:0] e, input logic [11:0] eh);
        bus.cont   = c;
        bus.p_reg  = p;
        bus.sh_num = sh;
        bus.esh    = es;
        bus.E      = e;
        bus.E_H    = eh;
    endtask

    task automatic beat(input string tag, input logic [2:0] c, input logic [74:0] p, input logic [9:0] sh,
                        input logic [1:0] es, input logic [11:0] e, input logic [11:0] eh,
                        input logic [55:0] x_norm, input logic [11:0] x_e, input logic [11:0] x_eh,
                        input logic [5:0] x_f);
        int lat;
        drive(c, p, sh, es, e, eh);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        while (lat < 8) begin
            @(negedge clk);
            if (bus.out_valid) break;
            lat++;
        end
        check({tag, ".lat"}, 64'(lat), 64'd1);
        check({tag, ".norm"}, 64'(bus.norm), 64'(x_norm));
        check({tag, ".E"}, 64'(bus.E_out), 64'(x_e));
        check({tag, ".E_H"}, 64'(bus.E_H_out), 64'(x_eh));
        check({tag, ".flags"}, 64'(bus.flags), 64'(x_f));
    endtask

    logic        mon_en = 1'b0;
    logic        pst = 1'b0;
    logic [55:0] pn;
    logic [11:0] pe;
    logic [11:0] got_q[$];
    int          stalls = 0;

    // while a stall is in progress the registered outputs must not move
    always @(negedge clk) begin
        if (mon_en) begin
            if (pst) begin
                check("stall.valid", 64'(bus.out_valid), 64'd1);
                check("stall.norm", 64'(bus.norm), 64'(pn));
                check("stall.E", 64'(bus.E_out), 64'(pe));
            end
            if (bus.out_valid && bus.out_ready) got_q.push_back(bus.E_out);
            if (bus.out_valid && !bus.out_ready) stalls++;
            pst = bus.out_valid && !bus.out_ready;
            pn  = bus.norm;
            pe  = bus.E_out;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.sgn       = 2'b00;
        bus.trap      = 8'h00;
        drive(3'b000, '0, '0, 2'b00, '0, '0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst.out_valid", 64'(bus.out_valid), 64'd0);
        check("rst.in_ready", 64'(bus.in_ready), 64'd1);
        check("rst.norm", 64'(bus.norm), 64'd0);
        check("rst.flags", 64'(bus.flags), 64'd0);

        beat("dbl",     3'b000, 75'h1 << 10, 10'd64, 2'b00, 12'd100, 12'd7, TOP, 12'd36, 12'd0, 6'b000000);
        beat("sgl",     3'b001, 75'h1 << 58, {5'd16, 5'd0}, 2'b00, 12'd5, 12'd10, TOP, 12'd0, 12'hFFA, 6'b010001);
        beat("stk",     3'b010, 75'h7FF_FFFF_FFFF_FFFF_FFFF, 10'd0, 2'b00, 12'd50, 12'd0,
             56'hFF_FFFF_FFFF_FFFF, 12'd50, 12'd0, 6'b000000);
        beat("stkA",    3'b000, 75'h4, 10'd8, 2'b00, 12'd30, 12'd0, 56'h1, 12'd22 - 12'(CORR), 12'd0, 6'b000000);
        beat("corr0",   3'b000, 75'h1 << 9, 10'd64, 2'b00, 12'd100, 12'd0,
             CORR ? TOP : 56'h40_0000_0000_0000, 12'd36 - 12'(CORR), 12'd0, 6'b000000);
        beat("corr1",   3'b000, 75'h1 << 9, 10'd64, 2'b01, 12'd100, 12'd0, TOP, 12'd35, 12'd0, 6'b000000);
        beat("eshtop",  3'b000, 75'h1 << 10, 10'd64, 2'b01, 12'd100, 12'd0,
             CORR ? TOP : 56'h0, CORR ? 12'd36 : 12'd35, 12'd0, 6'b000000);
        beat("ovf_d",   3'b000, 75'h1 << 74, 10'd0, 2'b00, 12'd2047, 12'd0, TOP, 12'h7FF, 12'd0, 6'b000100);
        beat("ovf_s",   3'b001, (75'h1 << 74) | (75'h1 << 36), 10'd0, 2'b00, 12'd255, 12'd300,
             56'h80_0000_0800_0000, 12'h0FF, 12'h12C, 6'b100100);
        beat("unf_d",   3'b000, 75'h1 << 74, 10'd0, 2'b00, 12'd0, 12'd0, TOP, 12'd0, 12'd0, 6'b000010);
        beat("clamp",   3'b000, 75'h1, 10'd127, 2'b00, 12'd100, 12'd0, TOP, 12'd26, 12'd0, 6'b000000);
        beat("zero",    3'b010, 75'h0, 10'd5, 2'b00, 12'd77, 12'd0, 56'h0, 12'd0, 12'd0, 6'b000001);
        bus.sgn  = 2'b10;
        bus.trap = 8'hA5;
        beat("unsup",   3'b011, 75'h1 << 74, 10'd0, 2'b00, 12'd100, 12'd9, 56'h0, 12'd0, 12'd0, 6'b000000);
        check("unsup.cont_o", 64'(bus.cont_o), 64'd3);
        check("unsup.sgn_o", 64'(bus.sgn_o), 64'd2);
        check("unsup.trap_o", 64'(bus.trap_o), 64'hA5);

        // four back-to-back beats tagged by exponent, with out_ready dropped for 3 cycles
        repeat (3) @(posedge clk);
        #1 mon_en = 1'b1;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    logic ok;
                    drive(3'b000, 75'h1 << 74, 10'd0, 2'b00, 12'(10 + k), 12'd0);
                    bus.in_valid = 1'b1;
                    for (int w = 0; w < 20; w++) begin
                        @(negedge clk);
                        ok = bus.in_ready;
                        @(posedge clk);
                        #1;
                        if (ok) break;
                    end
                end
                bus.in_valid = 1'b0;
            end
            begin
                repeat (2) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        for (int w = 0; w < 30 && got_q.size() < 4; w++) @(negedge clk);
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        check("bp.count", 64'(got_q.size()), 64'd4);
        for (int k = 0; k < 4; k++) check("bp.order", 64'(got_q[k]), 64'(10 + k));
        check("bp.stalled", 64'(stalls > 0), 64'd1);

        // reset with two beats in flight: nothing may emerge afterwards
        @(posedge clk);
        #1 drive(3'b000, 75'h1 << 74, 10'd0, 2'b00, 12'd60, 12'd0);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 check("rstmid.pre", 64'(bus.out_valid), 64'd1);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstmid.out_valid", 64'(bus.out_valid), 64'd0);
        check("rstmid.in_ready", 64'(bus.in_ready), 64'd1);
        check("rstmid.norm", 64'(bus.norm), 64'd0);
        begin
            int seen;
            seen = 0;
            repeat (5) begin
                @(negedge clk);
                seen += int'(bus.out_valid);
            end
            check("rstmid.emerged", 64'(seen), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
